// File: rtl/switch_pkg.sv
// Shared definitions for the switch array reader: read FSM encoding and default sizing.
package switch_pkg;

   localparam int unsigned DEF_WIDTH    = 32;
   localparam int unsigned DEF_DEBOUNCE = 50000;
   localparam int unsigned DEF_CNT_W    = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_WAIT = 2'd2
   } rd_state_e;

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus a single shared debounce counter for the whole switch vector.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] sw_in_i,
   output logic [WIDTH-1:0] value_o,
   output logic [WIDTH-1:0] value_d_o,
   output logic             changed_o,
   output logic             commit_o,
   output logic [WIDTH-1:0] rise_o,
   output logic [WIDTH-1:0] fall_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic [WIDTH-1:0] sync1_q, sw_s_q, sw_prev_q, value_q, value_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             changed_q;
   logic             commit;

   // Any change of the synchronised vector restarts the stability count.
   assign commit = (sw_s_q != value_q) && (sw_s_q == sw_prev_q) && (cnt_q == CNT_LAST);

   always_comb begin
      value_d = value_q;
      cnt_d   = cnt_q + 1'b1;
      if ((sw_s_q == value_q) || (sw_s_q != sw_prev_q)) begin
         cnt_d = '0;
      end else if (commit) begin
         value_d = sw_s_q;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q   <= '0;
         sw_s_q    <= '0;
         sw_prev_q <= '0;
         value_q   <= '0;
         cnt_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         sync1_q   <= sw_in_i;
         sw_s_q    <= sync1_q;
         sw_prev_q <= sw_s_q;
         value_q   <= value_d;
         cnt_q     <= cnt_d;
         changed_q <= commit;
      end
   end

   assign value_o   = value_q;
   assign value_d_o = value_d;
   assign changed_o = changed_q;
   assign commit_o  = commit;
   assign rise_o    = commit ? (sw_s_q & ~value_q) : '0;
   assign fall_o    = commit ? (~sw_s_q & value_q) : '0;

endmodule

// File: rtl/switch_array_reader.sv
// Debounced switch array with rise/fall edge accumulation, read out through a req/ack handshake.
module switch_array_reader
   import switch_pkg::*;
#(
   parameter int unsigned WIDTH    = DEF_WIDTH,
   parameter int unsigned DEBOUNCE = DEF_DEBOUNCE,
   parameter int unsigned CNT_W    = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] sw_in_i,
   output logic [WIDTH-1:0] value_o,
   output logic             changed_o,
   output logic             pending_o,
   input  logic             rd_req_i,
   output logic             rd_ack_o,
   output logic [WIDTH-1:0] rd_value_o,
   output logic [WIDTH-1:0] rd_rise_o,
   output logic [WIDTH-1:0] rd_fall_o
);

   rd_state_e        state_q;
   logic [WIDTH-1:0] rise_q, fall_q, rise_mrg, fall_mrg;
   logic [WIDTH-1:0] rd_value_q, rd_rise_q, rd_fall_q;
   logic [WIDTH-1:0] value_d, edge_rise, edge_fall;
   logic             pending_q, rd_ack_q, commit;

   switch_debounce #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE),
      .CNT_W    (CNT_W)
   ) u_debounce (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .sw_in_i   (sw_in_i),
      .value_o   (value_o),
      .value_d_o (value_d),
      .changed_o (changed_o),
      .commit_o  (commit),
      .rise_o    (edge_rise),
      .fall_o    (edge_fall)
   );

   // An edge committed in the capture cycle goes out with this read, not the next one.
   assign rise_mrg = rise_q | edge_rise;
   assign fall_mrg = fall_q | edge_fall;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         rise_q     <= '0;
         fall_q     <= '0;
         pending_q  <= 1'b0;
         rd_ack_q   <= 1'b0;
         rd_value_q <= '0;
         rd_rise_q  <= '0;
         rd_fall_q  <= '0;
      end else begin
         pending_q <= |(rise_q | fall_q);
         rd_ack_q  <= 1'b0;
         rise_q    <= rise_mrg;
         fall_q    <= fall_mrg;
         case (state_q)
            ST_IDLE: begin
               if (rd_req_i) begin
                  rd_value_q <= value_d;
                  rd_rise_q  <= rise_mrg;
                  rd_fall_q  <= fall_mrg;
                  rise_q     <= '0;
                  fall_q     <= '0;
                  state_q    <= ST_ACK;
               end
            end
            ST_ACK: begin
               rd_ack_q <= 1'b1;
               state_q  <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!rd_req_i) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign pending_o  = pending_q;
   assign rd_ack_o   = rd_ack_q;
   assign rd_value_o = rd_value_q;
   assign rd_rise_o  = rd_rise_q;
   assign rd_fall_o  = rd_fall_q;

endmodule

// File: tb/tb_switch_array_reader.sv
// Bench for switch_array_reader: pin-history reference model, read scoreboard, directed and random stimulus.
module tb_switch_array_reader;

   localparam int W  = 32;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          rd_req;
   logic [W-1:0]  sw_in;
   logic [W-1:0]  value_o, rd_value_o, rd_rise_o, rd_fall_o;
   logic          changed_o, pending_o, rd_ack_o;

   switch_array_reader #(.WIDTH(W), .DEBOUNCE(DB), .CNT_W(16)) dut (
      .clk_i      (clk),
      .reset_i    (reset),
      .sw_in_i    (sw_in),
      .value_o    (value_o),
      .changed_o  (changed_o),
      .pending_o  (pending_o),
      .rd_req_i   (rd_req),
      .rd_ack_o   (rd_ack_o),
      .rd_value_o (rd_value_o),
      .rd_rise_o  (rd_rise_o),
      .rd_fall_o  (rd_fall_o)
   );

   always #10 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int chg_count = 0;
   int ack_count = 0;

   typedef struct packed {
      logic [W-1:0] v;
      logic [W-1:0] r;
      logic [W-1:0] f;
   } rd_t;

   rd_t exp_q[$];

   // Reference model state: pin samples (index 0 = this edge), debounced value, masks, read phase.
   logic [W-1:0] p [7];
   logic [W-1:0] mval, mrise, mfall, mrv, mrr, mrf;
   logic         mchg, mpend, mack;
   int           phase;

   task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // A clean change is accepted once the synchronised vector (pins two edges old)
   // has held the same non-current value for DB+1 consecutive samples.
   always @(posedge clk) begin : model
      logic         ce;
      logic [W-1:0] cr, cf, nr, nf;
      if (reset) begin
         for (int k = 0; k < 7; k++) p[k] = '0;
         mval = '0; mrise = '0; mfall = '0;
         mrv = '0; mrr = '0; mrf = '0;
         mchg = 1'b0; mpend = 1'b0; mack = 1'b0;
         phase = 0;
         exp_q.delete();
      end else begin
         for (int k = 6; k > 0; k--) p[k] = p[k-1];
         p[0] = sw_in;
         ce = (p[2] != mval);
         for (int k = 3; k <= 2 + DB; k++) if (p[k] != p[2]) ce = 1'b0;
         cr = ce ? (p[2] & ~mval) : '0;
         cf = ce ? (~p[2] & mval) : '0;
         mpend = |(mrise | mfall);
         mchg  = ce;
         mack  = 1'b0;
         if (ce) mval = p[2];
         nr = mrise | cr;
         nf = mfall | cf;
         mrise = nr;
         mfall = nf;
         if (phase == 0) begin
            if (rd_req) begin
               mrv = mval; mrr = nr; mrf = nf;
               exp_q.push_back('{v: mval, r: nr, f: nf});
               mrise = '0; mfall = '0;
               phase = 1;
            end
         end else if (phase == 1) begin
            mack  = 1'b1;
            phase = 2;
         end else if (!rd_req) begin
            phase = 0;
         end
      end
   end

   always @(negedge clk) begin : monitor
      rd_t e;
      check("value", value_o, mval);
      check("changed", W'(changed_o), W'(mchg));
      check("pending", W'(pending_o), W'(mpend));
      check("rd_ack", W'(rd_ack_o), W'(mack));
      check("rd_value_held", rd_value_o, mrv);
      check("rd_rise_held", rd_rise_o, mrr);
      check("rd_fall_held", rd_fall_o, mrf);
      if (changed_o) chg_count++;
      if (rd_ack_o) begin
         ack_count++;
         if (exp_q.size() == 0) begin
            check("ack_unexpected", W'(1), W'(0));
         end else begin
            e = exp_q.pop_front();
            check("sb_rd_value", rd_value_o, e.v);
            check("sb_rd_rise", rd_rise_o, e.r);
            check("sb_rd_fall", rd_fall_o, e.f);
         end
      end
   end

   logic [W-1:0] lv, lr, lf;

   task automatic do_read(input int hold);
      bit got = 1'b0;
      @(negedge clk);
      rd_req = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (rd_ack_o) begin
            got = 1'b1;
            lv = rd_value_o; lr = rd_rise_o; lf = rd_fall_o;
         end
      end
      check("read_timeout", W'(got), W'(1));
      repeat (hold) @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int c0, a0;
      reset  = 1'b1;
      sw_in  = '1;
      rd_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_value", value_o, '0);
      check("reset_rd_ack", W'(rd_ack_o), W'(0));
      check("reset_pending", W'(pending_o), W'(0));
      reset = 1'b0;
      c0 = chg_count;
      for (int i = 1; i <= 7; i++) begin
         @(negedge clk);
         if (i == 6) check("value_before_7", value_o, '0);
         if (i == 7) check("value_at_7", value_o, '1);
      end
      repeat (5) @(negedge clk);
      check("reset_changed_once", W'(chg_count - c0), W'(1));

      // bounce on bit0
      sw_in = '0;
      repeat (12) @(negedge clk);
      c0 = chg_count;
      for (int i = 0; i < 5; i++) begin
         sw_in[0] = ~sw_in[0];
         repeat (2) @(negedge clk);
      end
      check("bounce_held_low", W'(value_o[0]), W'(0));
      repeat (12) @(negedge clk);
      check("bounce_settled", W'(value_o[0]), W'(1));
      check("bounce_one_change", W'(chg_count - c0), W'(1));

      do_read(0);
      repeat (3) @(negedge clk);

      // bit3 rise then fall, then read
      sw_in[3] = 1'b1;
      repeat (10) @(negedge clk);
      sw_in[3] = 1'b0;
      repeat (10) @(negedge clk);
      do_read(0);
      check("read_rise", lr, 32'h8);
      check("read_fall", lf, 32'h8);
      check("read_value_bit3", W'(lv[3]), W'(0));
      repeat (3) @(negedge clk);
      check("pending_cleared", W'(pending_o), W'(0));

      // held request
      a0 = ack_count;
      do_read(20);
      repeat (3) @(negedge clk);
      check("held_req_one_ack", W'(ack_count - a0), W'(1));

      // commit of bit5 lands on the capture edge
      @(negedge clk);
      sw_in[5] = 1'b1;
      repeat (5) @(negedge clk);
      do_read(0);
      check("collision_rise5", W'(lr[5]), W'(1));
      repeat (3) @(negedge clk);
      do_read(0);
      check("collision_next_rise", lr, '0);

      // reset during ACK
      sw_in = '0;
      repeat (12) @(negedge clk);
      check("pre_reset_pending", W'(pending_o), W'(1));
      a0 = ack_count;
      @(negedge clk);
      rd_req = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset_no_ack", W'(rd_ack_o), W'(0));
      reset  = 1'b0;
      rd_req = 1'b0;
      repeat (4) @(negedge clk);
      check("midreset_ack_count", W'(ack_count - a0), W'(0));
      check("midreset_pending", W'(pending_o), W'(0));
      do_read(0);
      check("midreset_rise", lr, '0);
      check("midreset_fall", lf, '0);

      // randomized pins and reads
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 3) != 3) begin
            sw_in = sw_in ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 1) == 1) sw_in = sw_in ^ (W'(1) << $urandom_range(0, 7));
            repeat ($urandom_range(1, 8)) @(negedge clk);
         end else begin
            do_read(int'($urandom_range(0, 3)));
         end
      end
      repeat (20) @(negedge clk);
      check("scoreboard_drained", W'(exp_q.size()), W'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
